// File: rtl/shift_add_mult_ctrl.sv
// shift_add_mult_ctrl: sequencer for an unsigned WIDTH x WIDTH shift-and-add
// multiplier that borrows an external 2*WIDTH-bit ripple adder.
// Operands are latched on an accepted start. One partial product is added per
// RUN cycle. The result is loaded into product with a one-cycle done pulse.
// Optional build macro: MULT_EARLY_TERM_EN ends RUN as soon as the remaining
// multiplier bits are all zero. Results are identical with or without it.
// Handshake: start is sampled only on a rising edge where ready=1 (IDLE);
// done is high for exactly one cycle, and product is then valid and held
// until the next accepted start.
module shift_add_mult_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 ready,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic                 ovf_err,
  output logic [2*WIDTH-1:0]   add_a,
  output logic [2*WIDTH-1:0]   add_b,
  output logic                 add_cin,
  input  logic [2*WIDTH-1:0]   add_sum,
  input  logic                 add_cout,
  output logic [1:0]           dbg_state
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [PW-1:0]     acc;
  logic [PW-1:0]     mcand;
  logic [WIDTH-1:0]  mplier;
  logic [CW-1:0]     count;
  logic              stepping;
  logic              take;
  logic [CW-1:0]     count_nxt;

  // RUN holds WIDTH add cycles followed by one settle cycle (count == LAST)
  // in which the final accumulator is handed over to product.
  assign stepping  = (state == RUN) && (count != LAST);
  assign take      = stepping && mplier[0];
  assign dbg_state = state;

  // Next step count; early termination jumps straight to the settle cycle
  // once no set multiplier bits remain after this shift.
  always_comb begin
`ifdef MULT_EARLY_TERM_EN
    count_nxt = ((mplier >> 1) == '0) ? LAST : count + CW'(1);
`else
    count_nxt = count + CW'(1);
`endif
  end

  // Adder operand muxing: only RUN drives the adder, otherwise it is quiescent.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a = acc;
      add_b = mcand;
    end
  end

  // Sequencer FSM with the datapath registers and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ready   <= 1'b1;
      done    <= 1'b0;
      product <= '0;
      ovf_err <= 1'b0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand  <= {{WIDTH{1'b0}}, multiplicand};
            mplier <= multiplier;
            acc    <= '0;
            count  <= '0;
            ready  <= 1'b0;
            state  <= RUN;
          end
        end
        RUN: begin
          if (stepping) begin
            if (mplier[0]) acc <= add_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count_nxt;
          end else begin
            product <= acc;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
      // A carry out of a full-width add can only come from a faulty adder.
      if (take && add_cout) ovf_err <= 1'b1;
    end
  end

endmodule
